// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div -- multi-cycle 32-bit restoring divider for the EX stage.
//
// One quotient bit is produced per clock. Signed operands are converted to
// magnitudes on acceptance, and the signs are restored at the end.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned divide (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       divide request, held high by EX until ready_o is seen
//   annul_i       cancel the operation in flight (flush / exception)
//   result_o      {remainder[63:32], quotient[31:0]}, registered
//   ready_o       result_o valid, registered
// ----------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dvd_q, dvd_d;        // {partial remainder, dividend/quotient, shift-in}
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] temp;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitude of an operand: only negated when dividing signed and negative.
    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;

        // Trial subtraction; a borrow in bit 32 means the divisor does not fit.
        temp = {1'b0, dvd_q[63:32]} - {1'b0, divisor_q};

        quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~dvd_q[31:0] + 32'd1)
                                                     : dvd_q[31:0];
        rem_fix  = (signed_q && sign1_q) ? (~dvd_q[64:33] + 32'd1)
                                         : dvd_q[64:33];

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = 64'h0;
                if (start_i && !annul_i) begin
                    signed_d  = signed_div_i;
                    sign1_d   = opdata1_i[31];
                    sign2_d   = opdata2_i[31];
                    divisor_d = mag(signed_div_i, opdata2_i);
                    dvd_d     = {32'h0, mag(signed_div_i, opdata1_i), 1'b0};
                    cnt_d     = 6'd0;
                    state_d   = (opdata2_i == 32'h0) ? S_BYZERO : S_ON;
                end
            end

            S_BYZERO: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else begin
                    // Result stays zero; ready is raised on the first END cycle.
                    dvd_d    = 65'h0;
                    result_d = 64'h0;
                    state_d  = S_END;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else if (!cnt_q[5]) begin
                    if (temp[32]) begin
                        dvd_d = {dvd_q[63:0], 1'b0};
                    end else begin
                        dvd_d = {temp[31:0], dvd_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    cnt_d    = 6'd0;
                    state_d  = S_END;
                end
            end

            S_END: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end

            default: begin
                state_d  = S_FREE;
                cnt_d    = 6'd0;
                ready_d  = 1'b0;
                result_d = 64'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FREE;
            cnt_q     <= 6'd0;
            dvd_q     <= 65'h0;
            divisor_q <= 32'h0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// ----------------------------------------------------------------------------
// tb_div -- directed bench for the div block: a vector table of complete
// requests plus hand-written sequences for annul, reset and operand changes.
// ----------------------------------------------------------------------------
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input int lat, input string name);
        vec_t v;
        v.sgn = s; v.a = a; v.b = b; v.res = res; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive a request; returns just after the acceptance edge T.
    task automatic request(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
    endtask

    // Called 'base' edges after acceptance; measures the edge at which ready rises.
    task automatic wait_ready(input string name, input int base, input int lat,
                              input logic [63:0] res);
        int          seen;
        logic [63:0] r;
        seen = 0;
        r    = 64'h0;
        for (int k = base + 1; k <= 40 && seen == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) begin
                seen = k;
                r    = result_o;
            end
        end
        chk({name, " latency"}, 64'(seen), 64'(lat));
        chk({name, " result"}, r, res);
    endtask

    // Hold start one more cycle, then drop it and expect a return to idle.
    task automatic finish_req(input string name, input logic [63:0] res);
        @(posedge clk);
        @(negedge clk);
        chk({name, " ready held"}, 64'(ready_o), 64'd1);
        chk({name, " result held"}, result_o, res);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, " ready drop"}, 64'(ready_o), 64'd0);
        chk({name, " result clear"}, result_o, 64'h0);
    endtask

    initial begin
        int cnt;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        add(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},       33, "u100_7");
        add(1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "s-7_2");
        add(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000}, 33, "s_min_m1");
        add(1'b0, 32'd5,          32'd0,        64'h0,                         2,  "u5_0");
        add(1'b1, 32'hFFFFFFFB,   32'd0,        64'h0,                         2,  "s-5_0");
        add(1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0,        32'hFFFFFFFF}, 33, "u_max_1");
        add(1'b0, 32'hFFFFFFF9,   32'd2,        {32'd1,        32'h7FFFFFFC}, 33, "u_fff9_2");
        add(1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}, 33, "s7_-2");
        add(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},        33, "s-7_-2");
        add(1'b0, 32'd3,          32'd10,       {32'd3,        32'd0},        33, "u3_10");
        add(1'b1, 32'd0,          32'd5,        64'h0,                         33, "s0_5");
        add(1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h0},        33, "u_8000_ffff");

        // Asynchronous reset between clock edges.
        #1 rst = 1'b0;
        #2;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            request(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_ready(vecs[i].name, 0, vecs[i].lat, vecs[i].res);
            finish_req(vecs[i].name, vecs[i].res);
        end

        // Annul during ON: pulse sampled at edge T+11, never completes.
        request(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        @(negedge clk);
        chk("annul_on ready", 64'(ready_o), 64'd0);
        chk("annul_on result", result_o, 64'h0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready_o) cnt++;
        end
        chk("annul_on no ready", 64'(cnt), 64'd0);
        request(1'b0, 32'd9, 32'd3);
        wait_ready("after_annul 9_3", 0, 33, {32'd0, 32'd3});
        finish_req("after_annul 9_3", {32'd0, 32'd3});

        // Annul while in BYZERO.
        request(1'b0, 32'd5, 32'd0);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready_o) cnt++;
        end
        chk("annul_byzero no ready", 64'(cnt), 64'd0);

        // Reset mid-ON, released with start still high: fresh acceptance.
        request(1'b0, 32'd100, 32'd7);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_on ready", 64'(ready_o), 64'd0);
        chk("rst_on result", result_o, 64'h0);
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        rst       = 1'b1;
        @(posedge clk);
        wait_ready("rst_restart 9_3", 0, 33, {32'd0, 32'd3});
        finish_req("rst_restart 9_3", {32'd0, 32'd3});

        // Reset while END holds a nonzero result.
        request(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_ready("pre_rst_end", 0, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_end ready", 64'(ready_o), 64'd0);
        chk("rst_end result", result_o, 64'h0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);

        // Operand changes during ON are ignored; ready held while start stays high.
        request(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b1;
        wait_ready("opchg", 5, 33, {32'd2, 32'd14});
        cnt = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o && result_o == {32'd2, 32'd14}) cnt++;
        end
        chk("opchg held cycles", 64'(cnt), 64'd5);
        finish_req("opchg", {32'd2, 32'd14});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 32 bits and result width at 64 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted); no synchronous reset path.
REQ-004 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
REQ-005 opdata1_i  input  32  dividend.
REQ-006 opdata2_i  input  32  divisor.
REQ-007 start_i  input  1  divide request from EX, held high by EX until ready_o is seen.
REQ-008 annul_i  input  1  cancel: pipeline flush or exception in progress.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}; EX writes [63:32] to HI and [31:0] to LO.
REQ-010 ready_o  output  1  result_o valid.

Function
REQ-011 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE: on start_i=1 and annul_i=0, the block SHALL accept.
- Acceptance SHALL latch signed_div_i, opdata1_i[31] and opdata2_i[31].
- If opdata2_i=0, next state SHALL be BYZERO.
- Otherwise next state SHALL be ON, with cnt=0.
- The internal 65-bit register SHALL load {32'b0, |op1|, 1'b0}.
- The latched divisor SHALL be |op2|.
- |x| is the two's-complement magnitude only when signed and x[31]=1; otherwise x unchanged.
REQ-013 FREE with start_i=0 or annul_i=1: the block SHALL stay in FREE, with ready_o=0 and result_o=0.
REQ-014 ON iteration (cnt<32), per cycle, restoring step:
- temp[32:0] = {1'b0, R[63:32]} - {1'b0, divisor}.
- If temp[32]=1: R <= R<<1.
- Else: R <= {temp[31:0], R[31:0], 1'b1}.
- cnt SHALL increment by 1.
REQ-015 ON with cnt=32, sign fix, then go to END:
- Quotient SHALL be negated when signed and latched op1[31]^op2[31]=1.
- Remainder SHALL be negated when signed and latched op1[31]=1.
- result_o SHALL be registered; ready_o SHALL become 1; cnt SHALL clear.
REQ-016 BYZERO SHALL proceed to END after one cycle, with result_o=0 and ready_o=1.
REQ-017 END SHALL hold result_o and ready_o=1 while start_i=1.
- On start_i=0, next state SHALL be FREE, with ready_o=0 and result_o=0 on that edge.
REQ-018 Latency: if acceptance occurs at edge T, then ready_o SHALL rise:
- at edge T+33 for a normal divide;
- at edge T+2 for divide-by-zero.
REQ-019 annul_i=1 in ON, BYZERO or END SHALL force FREE on the next edge, with ready_o=0, result_o=0 and cnt=0; annul SHALL take priority over iteration and completion.
REQ-020 Operands SHALL be sampled only at acceptance; changes to opdata*_i or signed_div_i during ON SHALL have no effect.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap or flag.
REQ-022 A new request SHALL NOT be accepted earlier than the cycle after return to FREE (no back-to-back acceptance in END).
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from inputs to ready_o or result_o.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force:
- state FREE and cnt=0;
- ready_o=0 and result_o=64'h0;
- the internal register and latched signs to 0.
REQ-025 Reset asserted mid-ON SHALL abandon the divide; after rst deassertion, start_i still high SHALL be accepted as a fresh request.

Verification
REQ-026 Unsigned 100/7 (signed_div_i=0), start_i held -> ready_o=1 at T+33, result_o={32'd2, 32'd14}.
REQ-027 Signed -7/2 (0xFFFFFFF9, 0x2) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; signed 0x80000000/0xFFFFFFFF -> {32'h0, 32'h80000000}.
REQ-028 Divide 5/0 -> ready_o=1 at T+2, result_o=0; drop start_i -> ready_o=0 and FREE next edge.
REQ-029 annul_i pulsed at T+10 of a 100/7 divide -> ready_o stays 0, FREE at T+11; a following 9/3 gives {0, 3} 33 cycles after its acceptance.
REQ-030 rst=0 asynchronously at T+20 (between edges) -> ready_o/result_o 0 immediately; release with start_i=1 -> new acceptance, correct result.
REQ-031 Operands changed at T+5 during ON -> result matches the operands sampled at T; ready_o held high for the whole time start_i stays high in END.
